fibonacci_checker: RTL and testbench

FIBONACCI_CHECKER -- requirements
Module: fibonacci_checker

---
 rtl/fibonacci_checker_if.sv | 34 +++
 rtl/fibonacci_checker.sv | 129 ++++++++++++
 tb/tb_fibonacci_checker.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fibonacci_checker_if.sv
// ============================================================================
// Module : fibonacci_checker_if
// Brief  : Beat/status bundle between a Fibonacci term source and the checker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fibonacci_checker_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             restart;
  logic             in_valid;
  logic             in_dual;
  logic [WIDTH-1:0] in_num;
  logic [WIDTH-1:0] in_num2;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] expect_num;
  logic             err;
  logic [CNT_W-1:0] err_idx;
  logic             busy;

  modport master (
    output restart, in_valid, in_dual, in_num, in_num2,
    input  count, expect_num, err, err_idx, busy
  );

  modport slave (
    input  restart, in_valid, in_dual, in_num, in_num2,
    output count, expect_num, err, err_idx, busy
  );
endinterface

`default_nettype wire

// File: rtl/fibonacci_checker.sv
// ============================================================================
// Module : fibonacci_checker
// Brief  : Checks an incoming stream against 1,1,2,3,5,... (mod 2^WIDTH).
//          Dual-term beats are enabled by defining FIBONACCI_CHECKER_DUAL_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fibonacci_checker #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  fibonacci_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_FAIL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_idx_q, err_idx_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] sum_ab;
  logic [CNT_W-1:0] count_inc1;

  assign sum_ab     = a_q + b_q;
  assign count_inc1 = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_W'(1);

`ifdef FIBONACCI_CHECKER_DUAL_EN
  logic [CNT_W-1:0] count_inc2;
  assign count_inc2 = (count_q >= CNT_MAX - CNT_W'(1)) ? CNT_MAX : count_q + CNT_W'(2);
`else
  logic unused_dual;
  assign unused_dual = ^{bus.in_dual, bus.in_num2};
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    count_d   = count_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;

    if (bus.restart) begin
      state_d   = S_IDLE;
      a_d       = ONE;
      b_d       = ONE;
      count_d   = '0;
      err_d     = 1'b0;
      err_idx_d = '0;
    end else if (bus.in_valid && (state_q != S_FAIL)) begin
`ifdef FIBONACCI_CHECKER_DUAL_EN
      if (bus.in_dual) begin
        if (bus.in_num != a_q) begin
          state_d   = S_FAIL;
          err_d     = 1'b1;
          err_idx_d = count_q;
        end else if (bus.in_num2 != b_q) begin
          // first term was good, so the failing index is the second slot
          state_d   = S_FAIL;
          err_d     = 1'b1;
          err_idx_d = count_q + CNT_W'(1);
        end else begin
          state_d = S_TRACK;
          a_d     = sum_ab;
          b_d     = sum_ab + b_q;
          count_d = count_inc2;
        end
      end else
`endif
      begin
        if (bus.in_num != a_q) begin
          state_d   = S_FAIL;
          err_d     = 1'b1;
          err_idx_d = count_q;
        end else begin
          state_d = S_TRACK;
          a_d     = b_q;
          b_d     = sum_ab;
          count_d = count_inc1;
        end
      end
    end

    busy_d = (state_d == S_TRACK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      a_q       <= ONE;
      b_q       <= ONE;
      count_q   <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      count_q   <= count_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.expect_num = a_q;
  assign bus.err        = err_q;
  assign bus.err_idx    = err_idx_q;
  assign bus.busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_fibonacci_checker.sv
// ============================================================================
// Module : tb_fibonacci_checker
// Brief  : Directed scoreboard bench for fibonacci_checker (CNT_W=5 so the
//          counter saturates within a short run).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fibonacci_checker;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  typedef struct packed {
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] expn;
    logic             err;
    logic [CNT_W-1:0] idx;
    logic             busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  exp_t rst_e;

  // Fibonacci terms F1..F34 reduced mod 65536, computed by hand
  logic [15:0] fib [34] = '{
    16'd1,     16'd1,     16'd2,     16'd3,     16'd5,     16'd8,
    16'd13,    16'd21,    16'd34,    16'd55,    16'd89,    16'd144,
    16'd233,   16'd377,   16'd610,   16'd987,   16'd1597,  16'd2584,
    16'd4181,  16'd6765,  16'd10946, 16'd17711, 16'd28657, 16'd46368,
    16'd9489,  16'd55857, 16'd65346, 16'd55667, 16'd55477, 16'd45608,
    16'd35549, 16'd15621, 16'd51170, 16'd1255
  };

  fibonacci_checker_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  fibonacci_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(int c, int e, bit er, int ix, bit bz);
    exp_t r;
    r.count = CNT_W'(c);
    r.expn  = WIDTH'(e);
    r.err   = er;
    r.idx   = CNT_W'(ix);
    r.busy  = bz;
    return r;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive(input bit v, input bit d, input int n1, input int n2,
                       input bit rs, input exp_t e);
    @(negedge clk);
    bus.restart  = rs;
    bus.in_valid = v;
    bus.in_dual  = d;
    bus.in_num   = WIDTH'(n1);
    bus.in_num2  = WIDTH'(n2);
    exp_q.push_back(e);
  endtask

  task automatic single(input int n, input exp_t e);
    drive(1'b1, 1'b0, n, 16'hDEAD, 1'b0, e);
  endtask

  task automatic idle(input exp_t e);
    drive(1'b0, 1'b1, 16'h5555, 16'hAAAA, 1'b0, e);
  endtask

  task automatic summary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  // Monitor: each driven cycle's expected state is compared just after its edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("count",      bus.count,      mon_e.count);
        chk("expect_num", bus.expect_num, mon_e.expn);
        chk("err",        bus.err,        mon_e.err);
        chk("err_idx",    bus.err_idx,    mon_e.idx);
        chk("busy",       bus.busy,       mon_e.busy);
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout required completion");
    summary();
    $finish;
  end

  initial begin
    rst_e        = mk(0, 1, 1'b0, 0, 1'b0);
    bus.restart  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_dual  = 1'b0;
    bus.in_num   = '0;
    bus.in_num2  = '0;
    rst = 1'b0;
    idle(rst_e);
    idle(rst_e);
    rst = 1'b1;

    // long correct run: wraps at term 25, count saturates at 31
    for (int i = 0; i < 33; i++) begin
      single(fib[i], mk((i + 1 > 31) ? 31 : i + 1, fib[i+1], 1'b0, 0, 1'b1));
      if (i == 9) idle(mk(10, 89, 1'b0, 0, 1'b1));
    end
    drive(1'b1, 1'b0, 1, 0, 1'b1, rst_e);

    // mismatch on the very first term
    single(2, mk(0, 1, 1'b1, 0, 1'b0));
    single(1, mk(0, 1, 1'b1, 0, 1'b0));
    drive(1'b0, 1'b0, 0, 0, 1'b1, rst_e);

    // 1,1,2,4 fails at index 3; the following 5 is ignored
    single(1, mk(1, 1, 1'b0, 0, 1'b1));
    single(1, mk(2, 2, 1'b0, 0, 1'b1));
    single(2, mk(3, 3, 1'b0, 0, 1'b1));
    single(4, mk(3, 3, 1'b1, 3, 1'b0));
    single(5, mk(3, 3, 1'b1, 3, 1'b0));
    idle(mk(3, 3, 1'b1, 3, 1'b0));
    drive(1'b0, 1'b0, 0, 0, 1'b1, rst_e);

`ifdef FIBONACCI_CHECKER_DUAL_EN
    drive(1'b1, 1'b1, 1, 1, 1'b0, mk(2, 2, 1'b0, 0, 1'b1));
    drive(1'b1, 1'b1, 2, 3, 1'b0, mk(4, 5, 1'b0, 0, 1'b1));
    drive(1'b1, 1'b1, 5, 8, 1'b0, mk(6, 13, 1'b0, 0, 1'b1));
    drive(1'b1, 1'b1, 13, 22, 1'b0, mk(6, 13, 1'b1, 7, 1'b0));
    drive(1'b0, 1'b0, 0, 0, 1'b1, rst_e);
    drive(1'b1, 1'b1, 2, 1, 1'b0, mk(0, 1, 1'b1, 0, 1'b0));
    drive(1'b0, 1'b0, 0, 0, 1'b1, rst_e);
`else
    drive(1'b1, 1'b1, 1, 999, 1'b0, mk(1, 1, 1'b0, 0, 1'b1));
    drive(1'b1, 1'b1, 1, 999, 1'b0, mk(2, 2, 1'b0, 0, 1'b1));
    drive(1'b0, 1'b0, 0, 0, 1'b1, rst_e);
`endif

    // restart wins over a simultaneous beat
    for (int i = 0; i < 5; i++)
      single(fib[i], mk(i + 1, fib[i+1], 1'b0, 0, 1'b1));
    drive(1'b1, 1'b0, 8, 0, 1'b1, rst_e);
    single(1, mk(1, 1, 1'b0, 0, 1'b1));
    single(1, mk(2, 2, 1'b0, 0, 1'b1));
    single(2, mk(3, 3, 1'b0, 0, 1'b1));

    // asynchronous reset between edges
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_count",   bus.count,      0);
    chk("async_expect",  bus.expect_num, 1);
    chk("async_err",     bus.err,        0);
    chk("async_err_idx", bus.err_idx,    0);
    chk("async_busy",    bus.busy,       0);
    idle(rst_e);
    rst = 1'b1;
    single(1, mk(1, 1, 1'b0, 0, 1'b1));
    single(1, mk(2, 2, 1'b0, 0, 1'b1));

    repeat (3) @(negedge clk);
    chk("queue_drain", exp_q.size(), 0);
    summary();
    $finish;
  end

endmodule

`default_nettype wire
